// File: rtl/tiny_dnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tiny_dnn_pkg
// Description : Shared types and constants for the tiny_dnn register master.
// Revision    : 1.0 - initial release
// ============================================================================
package tiny_dnn_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_READ  = 2'b01,
    OP_POLL  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_BUS     = 2'b01,
    ERR_TIMEOUT = 2'b10,
    ERR_BAD_OP  = 2'b11
  } err_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WADDR = 3'd1,
    ST_WRESP = 3'd2,
    ST_RADDR = 3'd3,
    ST_RDATA = 3'd4,
    ST_PWAIT = 3'd5,
    ST_RSP   = 3'd6
  } state_e;

  localparam int unsigned REG_CTRL     = 0;
  localparam int unsigned REG_SRC      = 1;
  localparam int unsigned REG_DST      = 2;
  localparam int unsigned REG_W        = 3;
  localparam int unsigned REG_B        = 4;
  localparam int unsigned REG_IN_W     = 5;
  localparam int unsigned REG_IN_H     = 6;
  localparam int unsigned REG_IN_C     = 7;
  localparam int unsigned REG_OUT_W    = 8;
  localparam int unsigned REG_OUT_H    = 9;
  localparam int unsigned REG_OUT_C    = 10;
  localparam int unsigned REG_K_W      = 11;
  localparam int unsigned REG_K_H      = 12;
  localparam int unsigned REG_STRIDE   = 13;
  localparam int unsigned REG_PAD      = 14;
  localparam int unsigned REG_DD       = 15;

  localparam int unsigned CTRL_BWRITE    = 0;
  localparam int unsigned CTRL_START     = 1;
  localparam int unsigned CTRL_RELU      = 2;
  localparam int unsigned CTRL_POOL      = 3;
  localparam int unsigned CTRL_BIAS      = 4;
  localparam int unsigned CTRL_CONV      = 5;
  localparam int unsigned CTRL_FC        = 6;
  localparam int unsigned CTRL_BN        = 7;
  localparam int unsigned CTRL_DWCONV    = 8;
  localparam int unsigned CTRL_SRC_READY = 31;

  // Registers are 32-bit words, so the word index becomes a byte offset.
  function automatic logic [31:0] reg_byte_addr(input logic [31:0] base, input logic [3:0] idx);
    return base + {26'd0, idx, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/tiny_dnn_reg_master.sv
`default_nettype none
// ============================================================================
// Module      : tiny_dnn_reg_master
// Description : Command-driven AXI4-Lite master for write/read/poll of the
//               tiny_dnn register block; one transaction outstanding at most.
// Revision    : 1.0 - initial release
// ============================================================================
module tiny_dnn_reg_master
  import tiny_dnn_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter logic [15:0] POLL_MAX  = 16'd1023
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  input  logic [31:0] cmd_mask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        busy,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  state_e      state_q, state_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0] awaddr_q, awaddr_d, araddr_q, araddr_d, wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [1:0]  rsp_err_q, rsp_err_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] match_q, match_d, mask_q, mask_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        rsp_fire;
  logic [1:0]  rsp_code;
  logic        poll_hit;

  assign poll_hit = ((M_AXI_RDATA & mask_q) == (match_q & mask_q));

  always_comb begin
    state_d     = state_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    op_d        = op_q;
    match_d     = match_q;
    mask_d      = mask_q;
    poll_cnt_d  = poll_cnt_q;
    rsp_fire    = 1'b0;
    rsp_code    = ERR_OK;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d       = cmd_op;
          match_d    = cmd_data;
          mask_d     = cmd_mask;
          poll_cnt_d = '0;
          unique case (cmd_op)
            OP_WRITE: begin
              awaddr_d  = reg_byte_addr(ADDR_BASE, cmd_addr);
              wdata_d   = cmd_data;
              wstrb_d   = 4'hF;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = ST_WADDR;
            end
            OP_READ, OP_POLL: begin
              araddr_d  = reg_byte_addr(ADDR_BASE, cmd_addr);
              arvalid_d = 1'b1;
              state_d   = ST_RADDR;
            end
            default: begin
              rsp_data_d = '0;
              rsp_fire   = 1'b1;
              rsp_code   = ERR_BAD_OP;
            end
          endcase
        end
      end
      ST_WADDR: begin
        // AW and W complete independently; B is awaited only after both.
        if (M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WREADY)  wvalid_d  = 1'b0;
        if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
          bready_d = 1'b1;
          state_d  = ST_WRESP;
        end
      end
      ST_WRESP: begin
        if (M_AXI_BVALID) begin
          bready_d   = 1'b0;
          rsp_data_d = '0;
          rsp_fire   = 1'b1;
          rsp_code   = (M_AXI_BRESP != 2'b00) ? ERR_BUS : ERR_OK;
        end
      end
      ST_RADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RDATA;
        end
      end
      ST_RDATA: begin
        if (M_AXI_RVALID) begin
          rready_d   = 1'b0;
          rsp_data_d = M_AXI_RDATA;
          poll_cnt_d = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;
          if (M_AXI_RRESP != 2'b00) begin
            rsp_fire = 1'b1;
            rsp_code = ERR_BUS;
          end else if (op_q == OP_READ || poll_hit) begin
            rsp_fire = 1'b1;
            rsp_code = ERR_OK;
          end else if (poll_cnt_d >= POLL_MAX) begin
            rsp_fire = 1'b1;
            rsp_code = ERR_TIMEOUT;
          end else begin
            state_d = ST_PWAIT;
          end
        end
      end
      ST_PWAIT: begin
        arvalid_d = 1'b1;
        state_d   = ST_RADDR;
      end
      ST_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (rsp_fire) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = rsp_code;
      state_d     = ST_RSP;
    end

    cmd_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 2'b00;
      op_q        <= 2'b00;
      match_q     <= '0;
      mask_q      <= '0;
      poll_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      op_q        <= op_d;
      match_q     <= match_d;
      mask_q      <= mask_d;
      poll_cnt_q  <= poll_cnt_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign busy          = (state_q != ST_IDLE);
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_tiny_dnn_reg_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_tiny_dnn_reg_master
// Description : Directed bench for tiny_dnn_reg_master with a simple AXI-Lite
//               slave whose handshake delays and responses are set per step.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tiny_dnn_reg_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_addr = 4'd0;
  logic [31:0] cmd_data = 32'd0, cmd_mask = 32'd0;
  logic        rsp_valid, rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = 32'd0;

  int checks = 0;
  int errors = 0;

  // slave knobs
  int          aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [1:0]  bresp_val = 2'b00, rresp_val = 2'b00;
  int          match_at = 0;
  logic [31:0] rd_hit = 32'd0, rd_miss = 32'd0;

  // slave observations
  int          cyc = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_in_cmd = 0;
  int          aw_wait = 0, w_wait = 0, b_wait = 0;
  logic        aw_got = 1'b0, w_got = 1'b0, b_owed = 1'b0, r_owed = 1'b0;
  logic [31:0] aw_addr_seen = 32'd0, w_data_seen = 32'd0, ar_addr_seen = 32'd0;
  logic [3:0]  w_strb_seen = 4'd0;
  int          overlap_err = 0, w_stale = 0;
  logic        split_seen = 1'b0, ar_prev = 1'b0, last_r_valid = 1'b0;
  int          last_r_cyc = 0, gap_min = 1000, gap_max = 0;
  logic [2:0]  post_acc = 3'd0;

  always #5 clk = ~clk;

  tiny_dnn_reg_master #(
    .ADDR_BASE(32'h0),
    .POLL_MAX (16'd8)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_data     (cmd_data),
    .cmd_mask     (cmd_mask),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .M_AXI_AWADDR (awaddr),
    .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready),
    .M_AXI_WDATA  (wdata),
    .M_AXI_WSTRB  (wstrb),
    .M_AXI_WVALID (wvalid),
    .M_AXI_WREADY (wready),
    .M_AXI_BRESP  (bresp),
    .M_AXI_BVALID (bvalid),
    .M_AXI_BREADY (bready),
    .M_AXI_ARADDR (araddr),
    .M_AXI_ARVALID(arvalid),
    .M_AXI_ARREADY(arready),
    .M_AXI_RDATA  (rdata),
    .M_AXI_RRESP  (rresp),
    .M_AXI_RVALID (rvalid),
    .M_AXI_RREADY (rready)
  );

  // Slave: drives on the falling edge; handshakes counted here complete on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
        bresp = 2'b00; rresp = 2'b00; rdata = 32'd0;
        aw_got = 1'b0; w_got = 1'b0; b_owed = 1'b0; r_owed = 1'b0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_prev = 1'b0;
      end else begin
        if ((awvalid || wvalid || bready) && (arvalid || rready)) overlap_err++;
        if (awvalid && !wvalid && w_got) split_seen = 1'b1;
        if (wvalid && w_got) w_stale++;
        bvalid = b_owed && (b_wait >= b_delay);
        bresp  = bvalid ? bresp_val : 2'b00;
        if (bvalid && bready) begin
          b_hs++; b_owed = 1'b0; b_wait = 0;
        end else if (b_owed) b_wait++;
        rvalid = r_owed;
        rdata  = (match_at != 0 && r_in_cmd + 1 >= match_at) ? rd_hit : rd_miss;
        rresp  = rvalid ? rresp_val : 2'b00;
        if (rvalid && rready) begin
          r_in_cmd++; r_owed = 1'b0; last_r_cyc = cyc; last_r_valid = 1'b1;
        end
        if (awvalid) begin
          awready = (aw_wait >= aw_delay);
          if (awready) begin
            aw_hs++; aw_got = 1'b1; aw_addr_seen = awaddr; aw_wait = 0;
          end else aw_wait++;
        end else begin
          awready = 1'b0; aw_wait = 0;
        end
        if (wvalid) begin
          wready = (w_wait >= w_delay);
          if (wready) begin
            w_hs++; w_got = 1'b1; w_data_seen = wdata; w_strb_seen = wstrb; w_wait = 0;
          end else w_wait++;
        end else begin
          wready = 1'b0; w_wait = 0;
        end
        if (aw_got && w_got) begin
          b_owed = 1'b1; aw_got = 1'b0; w_got = 1'b0;
        end
        if (arvalid) begin
          if (!ar_prev && last_r_valid) begin
            if (cyc - last_r_cyc - 1 < gap_min) gap_min = cyc - last_r_cyc - 1;
            if (cyc - last_r_cyc - 1 > gap_max) gap_max = cyc - last_r_cyc - 1;
          end
          arready = 1'b1;
          ar_hs++; ar_addr_seen = araddr; r_owed = 1'b1;
        end else arready = 1'b0;
        ar_prev = arvalid;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input string field, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed %h expected %h", tag, field, obs, exp);
    end
  endtask

  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [3:0] addr,
                         input logic [31:0] data, input logic [31:0] mask,
                         input logic [31:0] exp_data, input logic [1:0] exp_err);
    int n;
    last_r_valid = 1'b0; r_in_cmd = 0; gap_min = 1000; gap_max = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    check(tag, "cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    post_acc = {awvalid, wvalid, arvalid};
    n = 0;
    while (!rsp_valid && n < 500) begin @(negedge clk); n++; end
    check(tag, "rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check(tag, "rsp_data", rsp_data, exp_data);
    check(tag, "rsp_err", {30'd0, rsp_err}, {30'd0, exp_err});
    @(negedge clk);
    check(tag, "held_valid", {31'd0, rsp_valid}, 32'd1);
    check(tag, "held_data", rsp_data, exp_data);
    check(tag, "held_err", {30'd0, rsp_err}, {30'd0, exp_err});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check(tag, "rsp_drop", {31'd0, rsp_valid}, 32'd0);
  endtask

  int aw0, w0, b0, ar0;

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset", "valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check("reset", "cmd_ready", {31'd0, cmd_ready}, 32'd0);
    check("reset", "awaddr", awaddr, 32'd0);
    check("reset", "wstrb", {28'd0, wstrb}, 32'd0);
    check("reset", "rsp", {rsp_data[29:0], rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset", "ready_after", {31'd0, cmd_ready}, 32'd1);

    // plain write, both channels ready at once
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_cmd("wr_idx1", 2'b00, 4'd1, 32'h3FF, 32'h0, 32'h0, 2'b00);
    check("wr_idx1", "post_acc", {29'd0, post_acc}, 32'd6);
    check("wr_idx1", "awaddr", aw_addr_seen, 32'h4);
    check("wr_idx1", "wdata", w_data_seen, 32'h3FF);
    check("wr_idx1", "wstrb", {28'd0, w_strb_seen}, 32'hF);
    check("wr_idx1", "b_hs", b_hs - b0, 32'd1);

    // W accepted three cycles before AW
    aw_delay = 3; split_seen = 1'b0;
    aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
    run_cmd("wr_split", 2'b00, 4'd5, 32'hCAFE_0001, 32'h0, 32'h0, 2'b00);
    check("wr_split", "split", {31'd0, split_seen}, 32'd1);
    check("wr_split", "aw_hs", aw_hs - aw0, 32'd1);
    check("wr_split", "w_hs", w_hs - w0, 32'd1);
    check("wr_split", "b_hs", b_hs - b0, 32'd1);
    check("wr_split", "awaddr", aw_addr_seen, 32'h14);
    aw_delay = 0;

    // AW accepted before W
    w_delay = 2; b0 = b_hs;
    run_cmd("wr_awfirst", 2'b00, 4'd2, 32'h1234_5678, 32'h0, 32'h0, 2'b00);
    check("wr_awfirst", "b_hs", b_hs - b0, 32'd1);
    check("wr_awfirst", "wdata", w_data_seen, 32'h1234_5678);
    w_delay = 0;

    // single reads
    match_at = 1; rd_hit = 32'h8000_0000; rd_miss = 32'h0; ar0 = ar_hs;
    run_cmd("rd_idx0", 2'b01, 4'd0, 32'h0, 32'h0, 32'h8000_0000, 2'b00);
    check("rd_idx0", "post_acc", {29'd0, post_acc}, 32'd1);
    check("rd_idx0", "araddr", ar_addr_seen, 32'h0);
    check("rd_idx0", "ar_hs", ar_hs - ar0, 32'd1);
    rd_hit = 32'hA5A5_1234;
    run_cmd("rd_idx15", 2'b01, 4'd15, 32'h0, 32'h0, 32'hA5A5_1234, 2'b00);
    check("rd_idx15", "araddr", ar_addr_seen, 32'h3C);

    // poll matching on the 4th read; other bits set to exercise the mask
    match_at = 4; rd_hit = 32'h8000_0000; rd_miss = 32'h7FFF_FFFF; ar0 = ar_hs;
    run_cmd("poll_hit4", 2'b10, 4'd0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 2'b00);
    check("poll_hit4", "ar_hs", ar_hs - ar0, 32'd4);
    check("poll_hit4", "gap_min", gap_min, 32'd1);
    check("poll_hit4", "gap_max", gap_max, 32'd1);

    // poll matching exactly on the last permitted read
    match_at = 8; rd_hit = 32'hFFFF_FFFF; rd_miss = 32'h0; ar0 = ar_hs;
    run_cmd("poll_hit8", 2'b10, 4'd0, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 2'b00);
    check("poll_hit8", "ar_hs", ar_hs - ar0, 32'd8);

    // poll timeout
    match_at = 0; rd_miss = 32'h0000_0001; ar0 = ar_hs;
    run_cmd("poll_tmo", 2'b10, 4'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 2'b10);
    check("poll_tmo", "ar_hs", ar_hs - ar0, 32'd8);
    check("poll_tmo", "gap_max", gap_max, 32'd1);

    // bus errors
    bresp_val = 2'b10;
    run_cmd("wr_berr", 2'b00, 4'd3, 32'h55, 32'h0, 32'h0, 2'b01);
    bresp_val = 2'b00;
    rresp_val = 2'b10; rd_miss = 32'h0000_0BAD; ar0 = ar_hs;
    run_cmd("poll_rerr", 2'b10, 4'd0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0BAD, 2'b01);
    check("poll_rerr", "ar_hs", ar_hs - ar0, 32'd1);
    rresp_val = 2'b00;

    // reserved op
    aw0 = aw_hs; ar0 = ar_hs;
    run_cmd("bad_op", 2'b11, 4'd7, 32'hFFFF_FFFF, 32'h0, 32'h0, 2'b11);
    check("bad_op", "bus_hs", (aw_hs - aw0) + (ar_hs - ar0), 32'd0);

    // reset while waiting for B
    b_delay = 20;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 4'd2; cmd_data = 32'hDEAD;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int n = 0; n < 20 && !bready; n++) @(negedge clk);
    check("rst_wresp", "bready_pre", {31'd0, bready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wresp", "valids", {26'd0, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 32'd0);
    check("rst_wresp", "cmd_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    b_delay = 0;
    repeat (4) @(negedge clk);
    check("rst_wresp", "no_rsp", {31'd0, rsp_valid}, 32'd0);
    b0 = b_hs;
    run_cmd("wr_after_rst", 2'b00, 4'd9, 32'h0000_00FF, 32'h0, 32'h0, 2'b00);
    check("wr_after_rst", "awaddr", aw_addr_seen, 32'h24);
    check("wr_after_rst", "b_hs", b_hs - b0, 32'd1);

    check("global", "overlap", overlap_err, 32'd0);
    check("global", "w_stale", w_stale, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
